// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-port ROM arbiter.
package rom_arb_pkg;

  // Requesting ports; also used to record which port was granted last.
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam int CNT_W         = 16;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 2480;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage : rom_arb_pkg

// File: rtl/rom_arb_port_rsp.sv
// Per-port response register: captures the ROM word on a grant, presents it
// for exactly one cycle, and keeps a saturating count of grants.
module rom_arb_port_rsp
  import rom_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             gnt,
  input  logic             addr_err,
  input  logic [WIDTH-1:0] rom_rdata,
  output logic             rvalid,
  output logic             err,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;

  // One-cycle response pulse built from the grant seen at this edge.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    if (reset) begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= gnt;
      err    <= gnt & addr_err;
      rdata  <= (gnt && !addr_err) ? rom_rdata : '0;
    end
  end

  // Grant counter that sticks at its maximum instead of wrapping.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else if (gnt && (count_q != CNT_MAX)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule : rom_arb_port_rsp

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one asynchronous ROM between a fetch port (i_*)
// and a load port (d_*). Grants are combinational; responses arrive one
// cycle later from the per-port response registers.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic             clock,
  input  logic             reset,

  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic             i_err,
  output logic [WIDTH-1:0] i_rdata,

  input  logic             d_req,
  input  logic [WIDTH-1:0] d_addr,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic             d_err,
  output logic [WIDTH-1:0] d_rdata,

  output logic [WIDTH-1:0] rom_address,
  input  logic [WIDTH-1:0] rom_rdata,

  output logic [CNT_W-1:0] i_count,
  output logic [CNT_W-1:0] d_count
);

  // Word-index limit sized to the word-index field of an address.
  localparam logic [WIDTH-3:0] DEPTH_LIM = (WIDTH-2)'(DEPTH);

  port_e last_grant;
  logic  i_addr_err;
  logic  d_addr_err;

  // Misaligned or past-the-end word addresses complete with an error.
  assign i_addr_err = (i_addr[1:0] != 2'b00) || (i_addr[WIDTH-1:2] >= DEPTH_LIM);
  assign d_addr_err = (d_addr[1:0] != 2'b00) || (d_addr[WIDTH-1:2] >= DEPTH_LIM);

  // Pick at most one winner; on conflict the port not granted last wins.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    i_gnt       = 1'b0;
    d_gnt       = 1'b0;
    rom_address = '0;
    if (!reset) begin
      if (i_req && (!d_req || (last_grant == PORT_D))) begin
        i_gnt       = 1'b1;
        rom_address = i_addr;
      end else if (d_req) begin
        d_gnt       = 1'b1;
        rom_address = d_addr;
      end
    end
  end

  // Remember the most recent winner; idle cycles leave it untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= PORT_D;
    end else if (i_gnt) begin
      last_grant <= PORT_I;
    end else if (d_gnt) begin
      last_grant <= PORT_D;
    end
  end

  rom_arb_port_rsp #(
    .WIDTH (WIDTH)
  ) u_i_rsp (
    .clock     (clock),
    .reset     (reset),
    .gnt       (i_gnt),
    .addr_err  (i_addr_err),
    .rom_rdata (rom_rdata),
    .rvalid    (i_rvalid),
    .err       (i_err),
    .rdata     (i_rdata),
    .count     (i_count)
  );

  rom_arb_port_rsp #(
    .WIDTH (WIDTH)
  ) u_d_rsp (
    .clock     (clock),
    .reset     (reset),
    .gnt       (d_gnt),
    .addr_err  (d_addr_err),
    .rom_rdata (rom_rdata),
    .rvalid    (d_rvalid),
    .err       (d_err),
    .rdata     (d_rdata),
    .count     (d_count)
  );

endmodule : rom_arbiter

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter with a small ROM model.
module tb_rom_arbiter;

  logic        clock;
  logic        reset;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_rdata;
  logic [31:0] rom_address, rom_rdata;
  logic [15:0] i_count, d_count;

  int n_cmp = 0;
  int n_err = 0;

  rom_arbiter dut (
    .clock       (clock),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_gnt       (i_gnt),
    .i_rvalid    (i_rvalid),
    .i_err       (i_err),
    .i_rdata     (i_rdata),
    .d_req       (d_req),
    .d_addr      (d_addr),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_err       (d_err),
    .d_rdata     (d_rdata),
    .rom_address (rom_address),
    .rom_rdata   (rom_rdata),
    .i_count     (i_count),
    .d_count     (d_count)
  );

  // Asynchronous ROM model: word 4 is DEADBEEF, every other word is C0DE0000 ^ address.
  assign rom_rdata = (rom_address == 32'h10) ? 32'hDEADBEEF : (32'hC0DE_0000 ^ rom_address);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; i_addr = '0; d_addr = '0;
    step();

    // Grants stay low while reset is high, even with both ports requesting.
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_addr = 32'h40; #1;
    check("rst_i_gnt", 32'(i_gnt), 32'd0);
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    check("rst_rom_addr", rom_address, 32'd0);
    step();
    i_req = 1'b0; d_req = 1'b0;
    check("rst_i_rvalid", 32'(i_rvalid), 32'd0);
    check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rst_i_rdata", i_rdata, 32'd0);
    check("rst_i_count", 32'(i_count), 32'd0);
    check("rst_d_count", 32'(d_count), 32'd0);

    // Single fetch request to word 4.
    reset = 1'b0; i_req = 1'b1; i_addr = 32'h10; #1;
    check("single_i_gnt", 32'(i_gnt), 32'd1);
    check("single_d_gnt", 32'(d_gnt), 32'd0);
    check("single_rom_addr", rom_address, 32'h10);
    step();
    i_req = 1'b0; #1;
    check("single_i_rvalid", 32'(i_rvalid), 32'd1);
    check("single_i_rdata", i_rdata, 32'hDEADBEEF);
    check("single_i_err", 32'(i_err), 32'd0);
    check("single_i_count", 32'(i_count), 32'd1);
    check("single_d_rvalid", 32'(d_rvalid), 32'd0);
    check("idle_rom_addr", rom_address, 32'd0);
    step();
    check("single_i_rvalid_end", 32'(i_rvalid), 32'd0);
    check("single_i_rdata_end", i_rdata, 32'd0);

    // Both ports requesting for four cycles right after reset: I, D, I, D.
    reset = 1'b1; step(); reset = 1'b0;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h20; d_addr = 32'h40;
    for (int k = 0; k < 4; k++) begin
      logic exp_i, exp_i_rv, exp_d_rv;
      exp_i    = (k % 2 == 0);
      exp_i_rv = (k > 0) && !exp_i;
      exp_d_rv = (k > 0) && exp_i;
      #1;
      check($sformatf("rr%0d_i_gnt", k), 32'(i_gnt), 32'(exp_i));
      check($sformatf("rr%0d_d_gnt", k), 32'(d_gnt), 32'(!exp_i));
      check($sformatf("rr%0d_rom_addr", k), rom_address, exp_i ? 32'h20 : 32'h40);
      check($sformatf("rr%0d_i_rvalid", k), 32'(i_rvalid), 32'(exp_i_rv));
      check($sformatf("rr%0d_d_rvalid", k), 32'(d_rvalid), 32'(exp_d_rv));
      check($sformatf("rr%0d_i_rdata", k), i_rdata, exp_i_rv ? 32'hC0DE0020 : 32'd0);
      check($sformatf("rr%0d_d_rdata", k), d_rdata, exp_d_rv ? 32'hC0DE0040 : 32'd0);
      step();
    end
    i_req = 1'b0; d_req = 1'b0; #1;
    check("rr_last_d_rvalid", 32'(d_rvalid), 32'd1);
    check("rr_last_d_rdata", d_rdata, 32'hC0DE0040);
    check("rr_last_i_rvalid", 32'(i_rvalid), 32'd0);
    check("rr_i_count", 32'(i_count), 32'd2);
    check("rr_d_count", 32'(d_count), 32'd2);
    step();

    // Error responses: misaligned, first word past the end; then the last valid word.
    d_req = 1'b1; d_addr = 32'h6; #1;
    check("err_mis_d_gnt", 32'(d_gnt), 32'd1);
    step();
    d_addr = 32'd9920; #1;
    check("err_mis_d_rvalid", 32'(d_rvalid), 32'd1);
    check("err_mis_d_err", 32'(d_err), 32'd1);
    check("err_mis_d_rdata", d_rdata, 32'd0);
    check("err_oob_d_gnt", 32'(d_gnt), 32'd1);
    step();
    d_addr = 32'h26BC; #1;
    check("err_oob_d_rvalid", 32'(d_rvalid), 32'd1);
    check("err_oob_d_err", 32'(d_err), 32'd1);
    check("err_oob_d_rdata", d_rdata, 32'd0);
    step();
    d_req = 1'b0; #1;
    check("last_word_d_rvalid", 32'(d_rvalid), 32'd1);
    check("last_word_d_err", 32'(d_err), 32'd0);
    check("last_word_d_rdata", d_rdata, 32'hC0DE26BC);
    check("err_d_count", 32'(d_count), 32'd5);
    step();
    check("err_idle_d_rvalid", 32'(d_rvalid), 32'd0);
    check("err_idle_d_err", 32'(d_err), 32'd0);

    // Fetch wins alone, then loses a conflict and drops its request ungranted.
    i_req = 1'b1; i_addr = 32'h20; step();
    d_req = 1'b1; d_addr = 32'h40; #1;
    check("drop_i_gnt", 32'(i_gnt), 32'd0);
    check("drop_d_gnt", 32'(d_gnt), 32'd1);
    step();
    i_req = 1'b0; #1;
    check("drop_d_gnt2", 32'(d_gnt), 32'd1);
    step();
    d_req = 1'b0; #1;
    check("drop_i_rvalid", 32'(i_rvalid), 32'd0);
    check("drop_i_count", 32'(i_count), 32'd3);
    check("drop_d_count", 32'(d_count), 32'd7);
    step();

    // Reset in the cycle after a grant discards the pending response.
    i_req = 1'b1; i_addr = 32'h10; step();
    i_req = 1'b0; reset = 1'b1; step();
    reset = 1'b0; #1;
    check("rsp_rst_i_rvalid", 32'(i_rvalid), 32'd0);
    check("rsp_rst_d_rvalid", 32'(d_rvalid), 32'd0);
    check("rsp_rst_i_count", 32'(i_count), 32'd0);
    check("rsp_rst_d_count", 32'(d_count), 32'd0);
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h20; d_addr = 32'h40; #1;
    check("rsp_rst_first_i_gnt", 32'(i_gnt), 32'd1);
    check("rsp_rst_first_d_gnt", 32'(d_gnt), 32'd0);
    step();
    i_req = 1'b0; d_req = 1'b0;

    // Load counter saturation from FFFE.
    dut.u_d_rsp.count_q = 16'hFFFE;
    d_req = 1'b1; d_addr = 32'h40;
    step();
    check("sat_d_count_1", 32'(d_count), 32'h0000FFFF);
    step();
    check("sat_d_count_2", 32'(d_count), 32'h0000FFFF);
    step();
    check("sat_d_count_3", 32'(d_count), 32'h0000FFFF);
    d_req = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_rom_arbiter
